// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period (rise to rise) of a synchronized input and flags a stuck line.
// Results strobe 3 clock edges after the input rises; there is no backpressure and oValid is a single-cycle pulse.
module pwm_capture #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iPWM,
  output logic [CNT_W-1:0] oHigh,
  output logic [CNT_W-1:0] oPeriod,
  output logic             oValid,
  output logic             oStuck,
  output logic             oLevel
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] high_out_d, period_out_d;
  logic             valid_d, stuck_d;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= iPWM;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise   = s2 & ~s3;
  assign oLevel = s2;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q  <= IDLE;
      period_q <= '0;
      high_q   <= '0;
      oHigh    <= '0;
      oPeriod  <= '0;
      oValid   <= 1'b0;
      oStuck   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      high_q   <= high_d;
      oHigh    <= high_out_d;
      oPeriod  <= period_out_d;
      oValid   <= valid_d;
      oStuck   <= stuck_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    high_d       = high_q;
    high_out_d   = oHigh;
    period_out_d = oPeriod;
    valid_d      = 1'b0;
    stuck_d      = oStuck;
    case (state_q)
      IDLE: begin
        // The arming edge only starts a measurement; nothing is reported yet.
        if (rise) begin
          state_d  = MEASURE;
          period_d = CNT_ONE;
          high_d   = CNT_ONE;
          stuck_d  = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_out_d = period_q;
          high_out_d   = high_q;
          valid_d      = 1'b1;
          period_d     = CNT_ONE;
          high_d       = CNT_ONE;
        end else if (period_q == CNT_TIMEOUT) begin
          period_out_d = '0;
          high_out_d   = '0;
          valid_d      = 1'b1;
          stuck_d      = 1'b1;
          state_d      = IDLE;
        end else begin
          period_d = period_q + CNT_ONE;
          high_d   = high_q + {{(CNT_W-1){1'b0}}, s2};
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected strobes (values and arrival cycle), a monitor checks them.
module tb_pwm_capture;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;

  logic             iClk = 1'b0;
  logic             iReset;
  logic             iPWM;
  logic [CNT_W-1:0] oHigh;
  logic [CNT_W-1:0] oPeriod;
  logic             oValid;
  logic             oStuck;
  logic             oLevel;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .iClk(iClk), .iReset(iReset), .iPWM(iPWM),
    .oHigh(oHigh), .oPeriod(oPeriod), .oValid(oValid),
    .oStuck(oStuck), .oLevel(oLevel)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    int high;
    int period;
    bit stuck;
    bit chk_lvl;
    bit lvl;
    int at_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  bit   armed = 1'b0;
  int   prev_h = 0;
  int   prev_p = 0;
  int   last_rise = 0;

  task automatic step(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic push(input int h, input int p, input bit st, input bit cl, input bit lv, input int c);
    exp_t x;
    x.high = h; x.period = p; x.stuck = st; x.chk_lvl = cl; x.lvl = lv; x.at_cyc = c;
    exp_q.push_back(x);
  endtask

  // Input rises before the next edge; the matching strobe is visible after the third edge.
  task automatic rise_edge();
    last_rise = cyc;
    iPWM = 1'b1;
    if (armed) push(prev_h, prev_p, 1'b0, 1'b0, 1'b0, cyc + 3);
  endtask

  task automatic pwm(input int h, input int l);
    rise_edge();
    step(h);
    iPWM = 1'b0;
    step(l);
    armed  = 1'b1;
    prev_h = h;
    prev_p = h + l;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (oHigh != 0 || oPeriod != 0 || oValid || oStuck || oLevel) begin
      errors++;
      $display("FAIL %s: got high=%0d period=%0d valid=%0b stuck=%0b level=%0b, want all 0",
               name, oHigh, oPeriod, oValid, oStuck, oLevel);
    end
  endtask

  task automatic check_flags(input string name, input bit st, input bit lv);
    checks++;
    if (oStuck != st || oLevel != lv) begin
      errors++;
      $display("FAIL %s: got stuck=%0b level=%0b, want stuck=%0b level=%0b", name, oStuck, oLevel, st, lv);
    end
  endtask

  initial begin
    iReset = 1'b1;
    iPWM   = 1'b0;

    fork
      forever begin
        @(negedge iClk);
        if (oValid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: got high=%0d period=%0d at cycle %0d, want no strobe",
                     oHigh, oPeriod, cyc);
          end else begin
            e = exp_q.pop_front();
            if (oHigh != CNT_W'(e.high) || oPeriod != CNT_W'(e.period) || oStuck != e.stuck ||
                cyc != e.at_cyc || (e.chk_lvl && oLevel != e.lvl)) begin
              errors++;
              $display("FAIL strobe: got high=%0d period=%0d stuck=%0b level=%0b cycle=%0d, want high=%0d period=%0d stuck=%0b level=%0b(chk %0b) cycle=%0d",
                       oHigh, oPeriod, oStuck, oLevel, cyc, e.high, e.period, e.stuck, e.lvl, e.chk_lvl, e.at_cyc);
            end
          end
        end
      end
    join_none

    step(1);
    for (int i = 0; i < 6; i++) begin
      iPWM = ~iPWM;
      step(1);
      check_zero("reset_hold");
    end
    iPWM = 1'b0;
    step(2);
    iReset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_zero("reset_release");
    end

    // Nominal duty; the first period only arms.
    pwm(25, 76);
    pwm(25, 76);
    pwm(25, 76);

    // Extreme duty and minimum resolvable period.
    pwm(100, 1);
    pwm(100, 1);
    pwm(1, 1);
    pwm(1, 1);
    pwm(1, 1);
    pwm(25, 76);

    // Stuck high: last rise reports the previous period, then times out.
    rise_edge();
    push(0, 0, 1'b1, 1'b1, 1'b1, last_rise + 3 + TIMEOUT);
    step(TIMEOUT + 10);
    check_flags("stuck_high_flags", 1'b1, 1'b1);
    iPWM = 1'b0;
    step(5);
    armed = 1'b0;
    pwm(25, 76);
    check_flags("stuck_clear", 1'b0, 1'b0);
    pwm(25, 76);

    // Stuck low: timeout measured from the last rise.
    push(0, 0, 1'b1, 1'b1, 1'b0, last_rise + 3 + TIMEOUT);
    step(TIMEOUT);
    check_flags("stuck_low_flags", 1'b1, 1'b0);
    armed = 1'b0;

    // Reset 40 cycles into a period discards the partial measurement.
    pwm(25, 76);
    pwm(25, 76);
    rise_edge();
    step(25);
    iPWM = 1'b0;
    step(15);
    iReset = 1'b1;
    step(1);
    check_zero("reset_mid");
    step(1);
    check_zero("reset_mid_hold");
    iReset = 1'b0;
    step(36);
    armed = 1'b0;
    pwm(25, 76);
    pwm(25, 76);
    rise_edge();
    step(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL strobes_missing: got %0d outstanding, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
